// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//
// Round-robin scheduler sharing one non-pipelined CORDIC core among N_REQ
// requesters. A request (angle) is accepted through a valid/ready handshake,
// issued to the core with a single start pulse, and the x/y result is returned
// on one shared response channel tagged with the owning requester's ID. Only
// one operation is ever in flight.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset (shared with the core)
//   req_valid   [N_REQ]            per-requester request valid
//   req_angle   [N_REQ*BIT_WIDTH]  flattened angles, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   req_ready   [N_REQ]            one-hot accept pulse (combinational, IDLE only)
//   resp_valid  response available (registered)
//   resp_ready  consumer accepts response
//   resp_id     [ID_W]             requester owning the response
//   resp_x/y    [BIT_WIDTH]        captured core result
//   resp_err    response produced by the watchdog instead of the core
//   core_start  one-cycle start pulse to the core
//   core_angle  [BIT_WIDTH]        registered angle to the core
//   core_ready  core idle indication
//   core_done   core completion (may be a level held from the previous op)
//   core_x/y    [BIT_WIDTH]        core results
//
// Optional build macro:
//   CORDIC_ARB_TIMEOUT_EN  adds a BUSY watchdog of TIMEOUT_CYCLES cycles; on
//                          expiry an error response (x=y=0, resp_err=1) is sent.
//                          Without it BUSY waits indefinitely and resp_err is 0.
// -----------------------------------------------------------------------------
module cordic_arbiter #(
    parameter int BIT_WIDTH      = 16,
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*BIT_WIDTH-1:0] req_angle,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [BIT_WIDTH-1:0]       resp_x,
    output logic [BIT_WIDTH-1:0]       resp_y,
    output logic                       resp_err,
    output logic                       core_start,
    output logic [BIT_WIDTH-1:0]       core_angle,
    input  logic                       core_ready,
    input  logic                       core_done,
    input  logic [BIT_WIDTH-1:0]       core_x,
    input  logic [BIT_WIDTH-1:0]       core_y
);

    // Elaboration-time parameter sanity checks.
    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_nreq
        $error("cordic_arbiter: N_REQ must be in 2..8");
    end
    if ((1 << ID_W) < N_REQ) begin : g_chk_idw
        $error("cordic_arbiter: ID_W too small for N_REQ");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_to
        $error("cordic_arbiter: TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic                seen_busy;

    logic [BIT_WIDTH-1:0] angle_arr [N_REQ];
    logic [ID_W-1:0]      cand;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_found;
    logic                 grant_fire;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
    logic [TO_W-1:0] to_cnt;
`else
    assign resp_err = 1'b0;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign angle_arr[i] = req_angle[i*BIT_WIDTH +: BIT_WIDTH];
    end

    // Round-robin search starting just after the last granted requester,
    // so the most recent winner is examined last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The reset term keeps req_ready low while reset is held, even though the
    // state register already reads IDLE.
    assign grant_fire = reset && (state == IDLE) && core_ready && grant_found;
    assign req_ready  = grant_fire ? (N_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            seen_busy  <= 1'b0;
            core_start <= 1'b0;
            core_angle <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_x     <= '0;
            resp_y     <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        core_angle <= angle_arr[grant_idx];
                        id_q       <= grant_idx;
                        rr_ptr     <= grant_idx;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    core_start <= 1'b0;
                    seen_busy  <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    to_cnt     <= '0;
`endif
                    state      <= BUSY;
                end

                BUSY: begin
                    // done is only trusted once the core has dropped ready for
                    // this operation; a done level left over from the previous
                    // op would otherwise return the old result.
                    if (!core_ready) begin
                        seen_busy <= 1'b1;
                    end
                    if (seen_busy && core_done) begin
                        resp_x     <= core_x;
                        resp_y     <= core_y;
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        resp_err   <= 1'b0;
`endif
                        state      <= RESP;
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_x     <= '0;
                        resp_y     <= '0;
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Round-robin scheduler that shares one non-pipelined cordic core among N_REQ requesters.
- Each requester hands over an angle through a valid/ready handshake. The arbiter latches it, starts the core and waits for completion.
- The x/y result returns on a single shared response channel, tagged with the requester ID.
- Sits between client blocks (e.g. NCO, phase rotators) and the cordic core. It is the only driver of the core's start and angle inputs.

Parameters:
- BIT_WIDTH, 16, angle and x/y width; matches the core's BIT_WIDTH.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= N_REQ.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when CORDIC_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_angle  in  N_REQ*BIT_WIDTH  flattened angles; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- req_ready  out  N_REQ  one-hot accept pulse.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_x  out  BIT_WIDTH  registered core x result.
- resp_y  out  BIT_WIDTH  registered core y result.
- resp_err  out  1  result invalid due to core timeout.
- core_start  out  1  to core start.
- core_angle  out  BIT_WIDTH  to core angle, registered.
- core_ready  in  1  from core ready.
- core_done  in  1  from core done.
- core_x  in  BIT_WIDTH  from core out_x.
- core_y  in  BIT_WIDTH  from core out_y.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=N_REQ-1.
  - All outputs 0: req_ready, resp_valid, resp_id, resp_x, resp_y, resp_err, core_start, core_angle.
  - Reset mid-operation aborts everything; the core is reset by the same net, so no stale result is ever returned.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid is set and core_ready=1, grant g = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - In the same cycle: req_ready[g]=1 (combinational, one cycle); latch core_angle <= req_angle[g], id <= g, rr_ptr <= g.
  - Go to ISSUE.
  - If core_ready=0, no grant is made and req_ready stays 0.
- ISSUE:
  - core_start=1 for exactly one cycle, then go to BUSY.
- BUSY:
  - core_start=0.
  - Set seen_busy when core_ready=0 is observed. This guards against a done level held over from the previous op.
  - When seen_busy=1 and core_done=1: latch resp_x<=core_x, resp_y<=core_y, resp_id<=id, resp_err<=0, resp_valid<=1. Go to RESP.
- RESP:
  - Hold all resp_* stable while resp_valid=1 and resp_ready=0.
  - On resp_valid and resp_ready: resp_valid<=0, go to IDLE.
  - A new grant is possible in the IDLE cycle that follows, so there is at most one operation in flight.
- Throughput:
  - Minimum from request accept to resp_valid = 2 + core latency cycles.
  - No new request is accepted until the previous response is consumed.
- Fairness:
  - The requester just granted has lowest priority next round.
  - Only one valid requester: granted repeatedly.
  - All valid: grants in order rr_ptr+1, +2, ..., wrapping from N_REQ-1 to 0.
- Requesters must hold req_valid and req_angle until they see req_ready. Dropping valid before the grant is legal; that requester is simply not granted.
- Simultaneous events:
  - resp_ready asserted in the same cycle resp_valid rises is accepted in the following cycle. resp_valid is registered, so the handshake counts only when both are high at a clock edge.
  - A req_valid change during BUSY or RESP is ignored until IDLE.

Optional Feature:
- Macro: CORDIC_ARB_TIMEOUT_EN.
- Defined:
  - An 8-to-16-bit counter (sized by clog2(TIMEOUT_CYCLES+1)) clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES before the completion condition, go to RESP with resp_valid=1, resp_err=1, resp_x=0, resp_y=0, resp_id=id.
- Not defined:
  - No counter; BUSY waits indefinitely and resp_err is tied 0.

Test Plan:
- Reset values: reset=0 mid-BUSY with req_valid=4'b1111 -> all outputs 0 the same cycle. After release, the first grant goes to requester 0 (rr_ptr=3).
- Single request: req_valid=4'b0100, angle=16'h8000; core model with 10-cycle latency -> req_ready=4'b0100 for one cycle, core_start one pulse, core_angle=16'h8000, resp_valid 12 cycles after accept, resp_id=2, resp_x/resp_y equal to the core outputs.
- Round robin: req_valid=4'b1111 held, resp_ready=1 -> grant order 0,1,2,3,0. A new grant is made only after each response handshake.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp_x/y/id stable, no req_ready pulses, core_start stays 0. resp_ready=1 -> one handshake, next grant follows in the IDLE cycle.
- Stale done: core model holds done=1 from the prior op and delays ready=0 by 1 cycle after start -> the result is captured only after seen_busy; the old x/y is never returned.
- Timeout (macro defined, TIMEOUT_CYCLES=64): core never asserts done -> after 64 BUSY cycles resp_valid=1, resp_err=1, resp_x=resp_y=0. Without the macro, resp_valid stays 0.
